// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register-file bridge.
// Optional feature macro used by the bridge: SPI_BURST_EN.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        HOLD
    } state_t;

    localparam int RW_BIT     = 7;   // command bit selecting read (1) or write (0)
    localparam int ADDR_MSB   = 5;   // top bit of the command address field
    localparam int FRAME_BITS = 8;   // bits per SPI byte

endpackage

// File: rtl/spi_reg_bridge_sync.sv
// Multi-stage synchronizer with registered rise/fall edge detection.
// The edge pulses and the level output are aligned: a pin edge shows up
// as a one-cycle pulse SYNC_STAGES+1 clocks later.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // Synchronizer chain followed by the level/edge register stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{INIT}};
            level <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            level <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~level;
            fall  <= ~chain[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that turns command/data frames into single-cycle
// register-file strobes. Optional burst mode: define SPI_BURST_EN.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic [7:0]        wr_data,
    output logic              read_en,
    input  logic [7:0]        rd_data,
    output logic              frame_err
);

    logic       sclk_level_unused, sclk_rise, sclk_fall;
    logic       cs_level_unused, cs_rise, cs_fall;
    logic       mosi, mosi_rise_unused, mosi_fall_unused;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       is_read;
    logic [1:0] rd_pipe;
    logic [7:0] shift_next;
`ifdef SPI_BURST_EN
    logic       first_byte;
`endif

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clock(clock), .reset_n(reset_n), .din(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .clock(clock), .reset_n(reset_n), .din(spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .din(spi_mosi),
        .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Byte value including the bit arriving on the current sclk rise.
    always_comb begin
        shift_next = {shift_in[6:0], mosi};
    end

    // MISO only carries data while a read byte is in flight.
    assign spi_miso = (state == DATA) && is_read && shift_out[7];

    // Frame FSM with registered strobes and read-data shifter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            is_read    <= 1'b0;
            rd_pipe    <= '0;
            address    <= '0;
            wr_data    <= '0;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SPI_BURST_EN
            first_byte <= 1'b0;
`endif
        end else begin
            write_en  <= 1'b0;
            read_en   <= 1'b0;
            frame_err <= 1'b0;
            rd_pipe   <= {rd_pipe[0], 1'b0};

            if (cs_rise) begin
                // cs_rise outranks a coincident sclk_rise; a partial byte is dropped.
                state   <= IDLE;
                bit_cnt <= '0;
                rd_pipe <= '0;
                if (bit_cnt != '0)
                    frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            bit_cnt   <= '0;
                            shift_in  <= '0;
                            shift_out <= '0;
                            state     <= CMD;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(FRAME_BITS - 1)) begin
                                address <= ADDR_W'(shift_next[ADDR_MSB:0]);
                                is_read <= shift_next[RW_BIT];
`ifdef SPI_BURST_EN
                                first_byte <= 1'b1;
`endif
                                if (shift_next[RW_BIT]) begin
                                    read_en    <= 1'b1;
                                    rd_pipe[0] <= 1'b1;
                                end
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // The fall that closes the command byte must not shift,
                        // so only falls after a data bit was sampled advance MISO.
                        if (sclk_fall && is_read && (bit_cnt != '0))
                            shift_out <= {shift_out[6:0], 1'b0};
                        if (sclk_rise) begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(FRAME_BITS - 1)) begin
                                if (!is_read) begin
                                    wr_data  <= shift_next;
                                    write_en <= 1'b1;
                                end
`ifdef SPI_BURST_EN
                                // Write addresses advance with the strobe that uses them;
                                // read addresses advance for the prefetch of the next byte.
                                first_byte <= 1'b0;
                                if (is_read) begin
                                    address    <= address + ADDR_W'(1);
                                    read_en    <= 1'b1;
                                    rd_pipe[0] <= 1'b1;
                                end else if (!first_byte) begin
                                    address <= address + ADDR_W'(1);
                                end
`else
                                state <= HOLD;
`endif
                            end
                        end
                    end
                    HOLD: begin
                        state <= HOLD;
                    end
                    default: state <= IDLE;
                endcase
            end

            // Register file data is valid the cycle after read_en.
            if (rd_pipe[1])
                shift_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: table of single frames plus
// hand-written reset, multi-byte and burst-read sequences.
module tb_spi_reg_bridge;

    localparam int HALF = 8;  // system clocks per SCLK phase

    logic       clock = 1'b0;
    logic       reset_n;
    logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [5:0] address;
    logic       write_en, read_en, frame_err;
    logic [7:0] wr_data, rd_data;

    int checks = 0;
    int errors = 0;

    logic [13:0] wq[$];   // {address, wr_data} per write_en
    logic [5:0]  rq[$];   // address per read_en
    int          fe_cnt;
    logic [7:0]  mem [64];

    always #5 clock = ~clock;

    spi_reg_bridge #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
        .clock(clock), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .address(address), .write_en(write_en),
        .wr_data(wr_data), .read_en(read_en), .rd_data(rd_data),
        .frame_err(frame_err)
    );

    // Register file read model: data registered one cycle after read_en.
    always @(posedge clock) begin
        if (read_en) rd_data <= mem[address];
    end

    // Strobe monitor, sampled on the falling clock edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (write_en) wq.push_back({address, wr_data});
            if (read_en)  rq.push_back(address);
            if (frame_err) fe_cnt++;
            if (write_en || read_en) begin
                checks++;
                if (write_en && read_en) begin
                    errors++;
                    $display("FAIL both_strobes: write_en=%0b read_en=%0b, required not both", write_en, read_en);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clock);
            rx[7-i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nbytes, input int last_bits,
                         output logic [7:0] r1, output logic [7:0] r2);
        logic [7:0] r0;
        r1 = '0;
        r2 = '0;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
        xfer_byte(b0, (nbytes == 1) ? last_bits : 8, r0);
        if (nbytes > 1) xfer_byte(b1, (nbytes == 2) ? last_bits : 8, r1);
        if (nbytes > 2) xfer_byte(b2, last_bits, r2);
        repeat (HALF) @(negedge clock);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4 * HALF) @(negedge clock);
    endtask

    task automatic clear_log();
        wq.delete();
        rq.delete();
        fe_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         nbytes;
        int         last_bits;
        int         exp_we;
        int         exp_re;
        int         exp_fe;
        logic [5:0] exp_addr;
        logic [7:0] exp_wd;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] r1, r2;

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0]  = 8'hC3;
        mem[1]  = 8'h96;
        mem[5]  = 8'h3C;
        mem[63] = 8'h5A;

        //           cmd    data   nb bits we re fe addr   wd     rx
        vecs[0] = '{8'h04, 8'hA5, 2, 8, 1, 0, 0, 6'h04, 8'hA5, 8'h00};
        vecs[1] = '{8'h85, 8'h00, 2, 8, 0, 1, 0, 6'h05, 8'h00, 8'h3C};
        vecs[2] = '{8'h06, 8'hFF, 2, 4, 0, 0, 1, 6'h06, 8'h00, 8'h00};
        vecs[3] = '{8'h3F, 8'h00, 2, 8, 1, 0, 0, 6'h3F, 8'h00, 8'h00};
        vecs[4] = '{8'h45, 8'h77, 2, 8, 1, 0, 0, 6'h05, 8'h77, 8'h00};
        vecs[5] = '{8'h10, 8'h00, 1, 8, 0, 0, 0, 6'h10, 8'h00, 8'h00};
        vecs[6] = '{8'h80, 8'h00, 2, 8, 0, 1, 0, 6'h00, 8'h00, 8'hC3};

        reset_n  = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rd_data  = 8'h00;
        fe_cnt   = 0;
        repeat (4) @(negedge clock);
        chk("reset_miso",      {31'd0, spi_miso},  32'd0);
        chk("reset_address",   {26'd0, address},   32'd0);
        chk("reset_wr_data",   {24'd0, wr_data},   32'd0);
        chk("reset_write_en",  {31'd0, write_en},  32'd0);
        chk("reset_read_en",   {31'd0, read_en},   32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            clear_log();
            frame(vecs[v].cmd, vecs[v].data, 8'h00, vecs[v].nbytes, vecs[v].last_bits, r1, r2);
            chk($sformatf("v%0d_we_count", v), wq.size(), vecs[v].exp_we);
            chk($sformatf("v%0d_re_count", v), rq.size(), vecs[v].exp_re);
            chk($sformatf("v%0d_fe_count", v), fe_cnt, vecs[v].exp_fe);
            chk($sformatf("v%0d_miso", v), {24'd0, r1}, {24'd0, vecs[v].exp_rx});
            if (vecs[v].exp_we != 0 && wq.size() > 0)
                chk($sformatf("v%0d_write", v), {18'd0, wq[0]}, {18'd0, vecs[v].exp_addr, vecs[v].exp_wd});
            if (vecs[v].exp_re != 0 && rq.size() > 0)
                chk($sformatf("v%0d_read_addr", v), {26'd0, rq[0]}, {26'd0, vecs[v].exp_addr});
        end

        // Three-byte write frame.
        clear_log();
        frame(8'h20, 8'h11, 8'h22, 3, 8, r1, r2);
        chk("multi_fe", fe_cnt, 0);
        chk("multi_re", rq.size(), 0);
`ifdef SPI_BURST_EN
        chk("multi_we_count", wq.size(), 2);
        if (wq.size() > 1) chk("multi_write1", {18'd0, wq[1]}, {18'd0, 6'h21, 8'h22});
`else
        chk("multi_we_count", wq.size(), 1);
`endif
        if (wq.size() > 0) chk("multi_write0", {18'd0, wq[0]}, {18'd0, 6'h20, 8'h11});

        // Reset in the middle of a command byte, then a clean write.
        clear_log();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
        xfer_byte(8'h81, 3, r1);
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_mid_we", {31'd0, write_en}, 32'd0);
        chk("rst_mid_re", {31'd0, read_en}, 32'd0);
        reset_n = 1'b1;
        repeat (4 * HALF) @(negedge clock);
        chk("rst_mid_no_strobe", wq.size() + rq.size(), 0);
        chk("rst_mid_no_fe", fe_cnt, 0);
        frame(8'h25, 8'h1F, 8'h00, 2, 8, r1, r2);
        chk("post_rst_we_count", wq.size(), 1);
        if (wq.size() > 0) chk("post_rst_write", {18'd0, wq[0]}, {18'd0, 6'h25, 8'h1F});

        // Two-byte read starting at the top of the address space.
        clear_log();
        frame(8'hBF, 8'h00, 8'h00, 3, 8, r1, r2);
        chk("wrap_rx0", {24'd0, r1}, {24'd0, 8'h5A});
        chk("wrap_we", wq.size(), 0);
        if (rq.size() > 0) chk("wrap_read_addr0", {26'd0, rq[0]}, {26'd0, 6'h3F});
`ifdef SPI_BURST_EN
        chk("wrap_re_count", rq.size(), 3);
        if (rq.size() > 1) chk("wrap_read_addr1", {26'd0, rq[1]}, 32'd0);
        chk("wrap_rx1", {24'd0, r2}, {24'd0, 8'hC3});
`else
        chk("wrap_re_count", rq.size(), 1);
        chk("wrap_rx1", {24'd0, r2}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
